intt_butterfly: RTL and testbench

Pipelined Gentleman-Sande butterfly for the Kyber inverse NTT (q = 3329), the counterpart of the forward-NTT Montgomery multiply datapath. Per accepted pair it produces a' = barrett(a + b) and b' = fqmul(zeta, b − a). A scale mode applies the final n⁻¹·R² factor (1441) to both lanes. It sits between the polynomial RAM read port and write-back, with a valid/ready handshake on both sides and a tag that travels with the data.

---
 rtl/ntt_pkg.sv | 41 ++++
 rtl/mont_reduce_stage.sv | 11 +
 rtl/intt_butterfly.sv | 122 ++++++++++++
 tb/tb_intt_butterfly.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared Kyber NTT constants and modular reductions, used by both the forward and
// inverse butterfly datapaths so that their arithmetic stays bit-identical.
package ntt_pkg;

    localparam int KYBER_Q    = 3329;
    localparam int KYBER_QINV = -3327;
    localparam int BARRETT_V  = 20159;
    localparam int INTT_F     = 1441;

    localparam logic signed [31:0] Q32    = 32'(KYBER_Q);
    localparam logic signed [15:0] Q16    = 16'(KYBER_Q);
    localparam logic signed [31:0] QINV32 = 32'(KYBER_QINV);
    localparam logic signed [31:0] V32    = 32'(BARRETT_V);
    localparam logic signed [31:0] RND32  = 32'sd33554432;

    // Montgomery reduction: returns t * 2^-16 mod q, |result| < q for in-range t.
    function automatic logic signed [15:0] mont_reduce(input logic signed [31:0] t);
        logic signed [31:0] tq;
        logic signed [15:0] m;
        logic signed [31:0] mw;
        logic signed [31:0] r;
        tq = t * QINV32;
        m  = tq[15:0];
        mw = {{16{m[15]}}, m};
        r  = t - mw * Q32;
        return r[31:16];
    endfunction

    function automatic logic signed [15:0] barrett_quot(input logic signed [15:0] x);
        logic signed [31:0] xw;
        logic signed [31:0] p;
        xw = {{16{x[15]}}, x};
        p  = (xw * V32 + RND32) >>> 26;
        return p[15:0];
    endfunction

    function automatic logic signed [15:0] barrett_reduce(input logic signed [15:0] x);
        return x - barrett_quot(x) * Q16;
    endfunction

endpackage

// File: rtl/mont_reduce_stage.sv
// Combinational Montgomery reduction of a 32-bit product down to a 16-bit residue.
module mont_reduce_stage
    import ntt_pkg::*;
(
    input  logic signed [31:0] t,
    output logic signed [15:0] u
);

    assign u = mont_reduce(t);

endmodule

// File: rtl/intt_butterfly.sv
// Three-stage Gentleman-Sande inverse-NTT butterfly with an n^-1 scale mode.
// Global-stall pipeline: every stage advances together whenever the output is free.
module intt_butterfly
    import ntt_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_scale,
    input  logic signed [15:0]      in_a,
    input  logic signed [15:0]      in_b,
    input  logic signed [15:0]      in_zeta,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [15:0]      out_a,
    output logic signed [15:0]      out_b,
    output logic [TAG_W-1:0]        out_tag
);

    localparam logic signed [15:0] F16 = 16'(INTT_F);

    function automatic logic signed [31:0] mul16(input logic signed [15:0] x,
                                                 input logic signed [15:0] y);
        logic signed [31:0] xw;
        logic signed [31:0] yw;
        xw = {{16{x[15]}}, x};
        yw = {{16{y[15]}}, y};
        return xw * yw;
    endfunction

    logic en;

    logic [3:1]          vld_q, vld_d;

    logic signed [15:0]  s1_x_q, s1_x_d;
    logic signed [15:0]  s1_y_q, s1_y_d;
    logic signed [15:0]  s1_op_q, s1_op_d;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
    logic                s1_scale_q, s1_scale_d;

    logic signed [31:0]  s2_pa_q, s2_pa_d;
    logic signed [31:0]  s2_pb_q, s2_pb_d;
    logic signed [15:0]  s2_k_q, s2_k_d;
    logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;
    logic                s2_scale_q, s2_scale_d;

    logic signed [15:0]  out_a_q, out_a_d;
    logic signed [15:0]  out_b_q, out_b_d;
    logic [TAG_W-1:0]    out_tag_q, out_tag_d;

    logic signed [15:0]  mont_a, mont_b;

    assign out_valid = vld_q[3];
    assign en        = !vld_q[3] || out_ready;
    assign in_ready  = en;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_tag   = out_tag_q;

    mont_reduce_stage u_mont_a (.t(s2_pa_q), .u(mont_a));
    mont_reduce_stage u_mont_b (.t(s2_pb_q), .u(mont_b));

    always_comb begin
        vld_d      = {vld_q[2:1], in_valid};

        s1_x_d     = in_scale ? in_a : in_a + in_b;
        s1_y_d     = in_scale ? in_b : in_b - in_a;
        s1_op_d    = in_scale ? F16 : in_zeta;
        s1_tag_d   = in_tag;
        s1_scale_d = in_scale;

        // In butterfly mode lane A carries the raw sum; its Barrett quotient rides alongside.
        s2_pa_d    = s1_scale_q ? mul16(s1_x_q, s1_op_q) : {{16{s1_x_q[15]}}, s1_x_q};
        s2_pb_d    = mul16(s1_y_q, s1_op_q);
        s2_k_d     = barrett_quot(s1_x_q);
        s2_tag_d   = s1_tag_q;
        s2_scale_d = s1_scale_q;

        out_a_d    = s2_scale_q ? mont_a : s2_pa_q[15:0] - s2_k_q * Q16;
        out_b_d    = mont_b;
        out_tag_d  = s2_tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
            s1_scale_q <= 1'b0;
            s2_pa_q    <= '0;
            s2_pb_q    <= '0;
            s2_k_q     <= '0;
            s2_tag_q   <= '0;
            s2_scale_q <= 1'b0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_tag_q  <= '0;
        end else if (en) begin
            vld_q      <= vld_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s1_scale_q <= s1_scale_d;
            s2_pa_q    <= s2_pa_d;
            s2_pb_q    <= s2_pb_d;
            s2_k_q     <= s2_k_d;
            s2_tag_q   <= s2_tag_d;
            s2_scale_q <= s2_scale_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            out_tag_q  <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_intt_butterfly.sv
// Scoreboard bench for intt_butterfly: random and directed pairs against a flat
// integer model of the Kyber invntt butterfly step.
module tb_intt_butterfly;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                in_scale = 1'b0;
    logic signed [15:0]  in_a = '0;
    logic signed [15:0]  in_b = '0;
    logic signed [15:0]  in_zeta = '0;
    logic [7:0]          in_tag = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [15:0]  out_a;
    logic signed [15:0]  out_b;
    logic [7:0]          out_tag;

    intt_butterfly #(.TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_scale(in_scale),
        .in_a(in_a), .in_b(in_b), .in_zeta(in_zeta), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] a, b, z;
        logic               scale;
        logic [7:0]         tag;
        logic signed [15:0] exp_a, exp_b;
        int                 acc;
        bit                 lat;
        bit                 modb;
    } item_t;

    item_t sbq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Kyber reference arithmetic on plain ints.
    function automatic shortint fqmul(int x, int y);
        int      t;
        shortint m;
        int      u;
        t = x * y;
        m = shortint'(t * -3327);
        u = (t - m * 3329) >>> 16;
        return shortint'(u);
    endfunction

    function automatic shortint barrett(int xin);
        shortint x;
        int      k;
        x = shortint'(xin);
        k = (20159 * x + (1 << 25)) >>> 26;
        return shortint'(x - k * 3329);
    endfunction

    function automatic item_t model(item_t it);
        item_t r;
        r = it;
        if (it.scale) begin
            r.exp_a = fqmul(it.a, 1441);
            r.exp_b = fqmul(it.b, 1441);
        end else begin
            r.exp_a = barrett(it.a + it.b);
            r.exp_b = fqmul(it.z, shortint'(it.b - it.a));
        end
        return r;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic item_t rand_item(bit allow_scale);
        item_t it;
        it.a     = 16'($urandom_range(0, 32766)) - 16'sd16383;
        it.b     = 16'($urandom_range(0, 32766)) - 16'sd16383;
        it.z     = 16'($urandom);
        it.scale = allow_scale && ($urandom_range(0, 3) == 0);
        it.tag   = 8'($urandom);
        it.lat   = 1'b0;
        it.modb  = 1'b0;
        return model(it);
    endfunction

    // Monitor: compares the head of the scoreboard whenever a result is presented.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sbq[0];
                    check("out_tag", int'(out_tag), int'(e.tag));
                    check("out_a", int'(out_a), int'(e.exp_a));
                    if (e.modb)
                        check("out_b_congruent",
                              int'((int'(out_b) + 1000) % 3329 == 0 && out_b > -3329 && out_b < 3329), 1);
                    else
                        check("out_b", int'(out_b), int'(e.exp_b));
                    if (out_ready) begin
                        if (e.lat) check("latency", cyc - e.acc, 3);
                        void'(sbq.pop_front());
                    end else begin
                        check("in_ready_stalled", int'(in_ready), 0);
                    end
                end
            end
        end
    end

    task automatic issue(item_t it);
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_a = it.a; in_b = it.b; in_zeta = it.z; in_scale = it.scale; in_tag = it.tag;
            #1;
            if (in_ready) begin
                it.acc = cyc;
                sbq.push_back(it);
                done = 1;
            end
        end
        if (!done) check("issue_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Stream n items; out_ready low for stall_len cycles starting at stall_at; optional random bubbles.
    task automatic stream(int n, int stall_at, int stall_len, bit bubbles);
        item_t cur;
        bit    have = 0;
        int    sent = 0;
        int    c    = 0;
        while (sent < n && c < n + 400) begin
            @(negedge clk);
            out_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (!have) begin
                cur  = rand_item(1'b1);
                have = 1;
            end
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_a = cur.a; in_b = cur.b; in_zeta = cur.z; in_scale = cur.scale; in_tag = cur.tag;
            #1;
            if (in_valid && in_ready) begin
                cur.acc = cyc;
                sbq.push_back(cur);
                have = 0;
                sent++;
            end
            c++;
        end
        if (sent < n) check("stream_timeout", sent, n);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
        check("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        item_t it;

        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_a", int'(out_a), 0);
        check("rst_out_b", int'(out_b), 0);
        check("rst_out_tag", int'(out_tag), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Identity twiddle: zeta = 2^16 mod q.
        it = '{a:100, b:300, z:2285, scale:0, tag:8'h5A, exp_a:0, exp_b:0, acc:0, lat:1, modb:0};
        it = model(it);
        it.exp_a = 400; it.exp_b = 200;
        issue(it);
        drain();

        it = '{a:3000, b:2000, z:2285, scale:0, tag:8'h11, exp_a:0, exp_b:0, acc:0, lat:1, modb:1};
        it = model(it);
        it.exp_a = -1658;
        issue(it);
        drain();

        it = '{a:1, b:1, z:16'h7fff, scale:1, tag:8'hC3, exp_a:0, exp_b:0, acc:0, lat:1, modb:0};
        it = model(it);
        it.exp_a = 512; it.exp_b = 512;
        issue(it);
        drain();

        // Back-to-back full-rate stream.
        stream(64, 1000, 0, 1'b0);
        drain();

        // Backpressure mid-stream.
        stream(40, 10, 5, 1'b0);
        drain();

        // Bubbles plus a second stall.
        stream(40, 7, 5, 1'b1);
        drain();

        // Reset with three items in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            it = rand_item(1'b0);
            in_valid = 1'b1; out_ready = 1'b1;
            in_a = it.a; in_b = it.b; in_zeta = it.z; in_scale = it.scale; in_tag = it.tag;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_a", int'(out_a), 0);
        check("midrst_out_b", int'(out_b), 0);
        check("midrst_out_tag", int'(out_tag), 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", int'(in_ready), 1);
        repeat (6) @(negedge clk);

        stream(16, 4, 5, 1'b0);
        drain();
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
